// File: rtl/sweep_pkg.sv
// Shared constants for the equivalence sweep controller: FSM state codes,
// default evaluator width and the vec bit position of each evaluator variable.
package sweep_pkg;

  localparam int unsigned NVarsDefault = 4;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StApply  = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam int unsigned XBit = 3;
  localparam int unsigned YBit = 2;
  localparam int unsigned WBit = 1;
  localparam int unsigned ZBit = 0;

endpackage

// File: rtl/settle_timer.sv
// Counts the cycles a vector has been applied; expire_o marks the last APPLY cycle.
module settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/equiv_sweep.sv
// Walks every input vector of a boolean evaluator, captures both forms' truth
// tables and reports whether the two forms are equivalent.
module equiv_sweep import sweep_pkg::*; #(
  parameter int unsigned N_VARS = NVarsDefault,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 a_in,
  input  logic                 b_in,
  output logic [N_VARS-1:0]    vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_VARS:0]      mismatch_count,
  output logic                 fail_valid,
  output logic [N_VARS-1:0]    first_fail,
  output logic [2**N_VARS-1:0] tt_a,
  output logic [2**N_VARS-1:0] tt_b
);

  localparam int unsigned NVec = 2**N_VARS;
  localparam logic [N_VARS-1:0] VecLast = N_VARS'(NVec - 1);
  localparam logic [N_VARS-1:0] VecOne  = N_VARS'(1);
  localparam logic [N_VARS:0]   MmOne   = (N_VARS + 1)'(1);

  logic [1:0]        state_q, state_d;
  logic [N_VARS-1:0] vec_q, vec_d;
  logic [NVec-1:0]   tt_a_q, tt_a_d, tt_b_q, tt_b_d;
  logic [N_VARS:0]   mm_q, mm_d;
  logic              fv_q, fv_d, pass_q, pass_d;
  logic [N_VARS-1:0] ff_q, ff_d;
  logic              load, expire;

  settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .en_i    (state_q == StApply),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    tt_a_d  = tt_a_q;
    tt_b_d  = tt_b_q;
    mm_d    = mm_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StApply;
          vec_d   = '0;
          tt_a_d  = '0;
          tt_b_d  = '0;
          mm_d    = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          pass_d  = 1'b0;
          load    = 1'b1;
        end
      end
      StApply: begin
        if (expire) state_d = StSample;
      end
      StSample: begin
        tt_a_d[vec_q] = a_in;
        tt_b_d[vec_q] = b_in;
        if (a_in != b_in) begin
          mm_d = mm_q + MmOne;
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
        end
        // Verdict is registered on the way into DONE so it is already valid with the done pulse.
        if (vec_q == VecLast) begin
          state_d = StDone;
          pass_d  = (mm_d == '0);
        end else begin
          vec_d   = vec_q + VecOne;
          state_d = StApply;
          load    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      vec_q   <= '0;
      tt_a_q  <= '0;
      tt_b_q  <= '0;
      mm_q    <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tt_a_q  <= tt_a_d;
      tt_b_q  <= tt_b_d;
      mm_q    <= mm_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  assign vec            = vec_q;
  assign busy           = (state_q == StApply) || (state_q == StSample);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign mismatch_count = mm_q;
  assign fail_valid     = fv_q;
  assign first_fail     = ff_q;
  assign tt_a           = tt_a_q;
  assign tt_b           = tt_b_q;

endmodule
